// File: rtl/mb_crc3_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mb_crc3_rx
//  Description : Serial frame receiver. It takes 8 data bits, MSB first, then
//                3 CRC bits. It checks the frame against the CRC3 polynomial
//                x^3+x+1 and holds the byte until the consumer acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mb_crc3_rx (
    input  logic       GCLK,
    input  logic       CLEAR,
    input  logic       Ser_in,
    input  logic       Bit_en,
    input  logic       Frame_start,
    input  logic       Dack,
    output logic [7:0] Dout,
    output logic       Dvalid,
    output logic       ERROR,
    output logic       Overrun,
    output logic       Busy
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_CRC  = 2'd2;

    logic [1:0] r_state;
    logic [2:0] r_cnt;
    logic [2:0] r_lfsr;
    logic [7:0] r_shift;
    logic [7:0] r_dout;
    logic       r_dvalid;
    logic       r_error;
    logic       r_overrun;

    logic       w_fb;
    logic [2:0] w_lfsr_step;
    logic [2:0] w_lfsr_init;
    logic       w_start;
    logic       w_done;

    // LFSR next value for the current bit, and the value after one step from 000
    assign w_fb        = Ser_in ^ r_lfsr[2];
    assign w_lfsr_step = {r_lfsr[1], r_lfsr[0] ^ w_fb, w_fb};
    assign w_lfsr_init = {1'b0, Ser_in, Ser_in};

    // A strobed Frame_start always begins a new frame, even mid-frame.
    // Completion is the strobed edge that samples CRC bit 0, unless the same
    // edge restarts the frame.
    assign w_start = Bit_en & Frame_start;
    assign w_done  = Bit_en & ~Frame_start & (r_state == c_CRC) & (r_cnt == 3'd2);

    // Frame sequencing: state, bit counter, CRC register and data shifter
    always_ff @(posedge GCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
            r_lfsr  <= 3'd0;
            r_shift <= 8'd0;
        end else if (w_start) begin
            r_state <= c_DATA;
            r_cnt   <= 3'd1;
            r_lfsr  <= w_lfsr_init;
            r_shift <= {7'd0, Ser_in};
        end else if (Bit_en) begin
            case (r_state)
                c_DATA: begin
                    r_shift <= {r_shift[6:0], Ser_in};
                    r_lfsr  <= w_lfsr_step;
                    if (r_cnt == 3'd7) begin
                        r_state <= c_CRC;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_CRC: begin
                    r_lfsr <= w_lfsr_step;
                    if (r_cnt == 3'd2) begin
                        r_state <= c_IDLE;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_IDLE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    // Output holding register: load on completion, release on acknowledge
    always_ff @(posedge GCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_dout    <= 8'd0;
            r_dvalid  <= 1'b0;
            r_error   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done) begin
            r_dout   <= r_shift;
            r_error  <= (w_lfsr_step != 3'd0);
            r_dvalid <= 1'b1;
            // An acknowledge on the completion edge consumes the old byte, so
            // the sticky flag is left alone in that case
            if (r_dvalid && !Dack) begin
                r_overrun <= 1'b1;
            end
        end else if (Dack) begin
            r_dvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign Dout    = r_dout;
    assign Dvalid  = r_dvalid;
    assign ERROR   = r_error;
    assign Overrun = r_overrun;
    assign Busy    = (r_state == c_DATA) || (r_state == c_CRC);

endmodule
`default_nettype wire

// File: tb/tb_mb_crc3_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mb_crc3_rx
//  Description : Directed, table-driven self-checking bench for mb_crc3_rx
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mb_crc3_rx;

    logic       GCLK;
    logic       CLEAR;
    logic       Ser_in;
    logic       Bit_en;
    logic       Frame_start;
    logic       Dack;
    logic [7:0] Dout;
    logic       Dvalid;
    logic       ERROR;
    logic       Overrun;
    logic       Busy;

    int n_pass  = 0;
    int n_total = 0;

    mb_crc3_rx u_dut (
        .GCLK        (GCLK),
        .CLEAR       (CLEAR),
        .Ser_in      (Ser_in),
        .Bit_en      (Bit_en),
        .Frame_start (Frame_start),
        .Dack        (Dack),
        .Dout        (Dout),
        .Dvalid      (Dvalid),
        .ERROR       (ERROR),
        .Overrun     (Overrun),
        .Busy        (Busy)
    );

    initial GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    typedef struct {
        logic [7:0] data;
        logic [2:0] crc;
        logic [7:0] exp_dout;
        logic       exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    // Sends nbits bits of the frame {data, crc}, MSB first, with gap Bit_en=0
    // cycles after each strobe. It reports the edge index at which Dvalid first
    // rises, and whether Busy was high on every edge before the last CRC bit.
    task automatic send_frame(input logic [7:0] d, input logic [2:0] c, input int gap,
                              input int nbits, input bit ack_last, input bit use_start,
                              output int done_edge, output bit busy_ok);
        logic [10:0] bits;
        logic        prev;
        int          edge_n;
        bits      = {d, c};
        prev      = Dvalid;
        edge_n    = 0;
        done_edge = -1;
        busy_ok   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            Ser_in      = bits[10-i];
            Bit_en      = 1'b1;
            Frame_start = use_start && (i == 0);
            Dack        = ack_last && (i == nbits - 1);
            tick();
            edge_n++;
            if (!prev && Dvalid && done_edge < 0) done_edge = edge_n;
            prev = Dvalid;
            if (i < 10 && Busy !== 1'b1) busy_ok = 1'b0;
            Bit_en      = 1'b0;
            Frame_start = 1'b0;
            Dack        = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                edge_n++;
                if (!prev && Dvalid && done_edge < 0) done_edge = edge_n;
                prev = Dvalid;
                if (i < 10 && Busy !== 1'b1) busy_ok = 1'b0;
            end
        end
    endtask

    task automatic ack_pulse();
        Dack = 1'b1;
        tick();
        Dack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int de;
        bit bo;

        // Expected CRCs are (data * x^3) mod (x^3+x+1), worked out by hand
        vecs[0] = '{8'h80, 3'b011, 8'h80, 1'b0};
        vecs[1] = '{8'h80, 3'b010, 8'h80, 1'b1};
        vecs[2] = '{8'h00, 3'b000, 8'h00, 1'b0};
        vecs[3] = '{8'h01, 3'b011, 8'h01, 1'b0};
        vecs[4] = '{8'h02, 3'b110, 8'h02, 1'b0};
        vecs[5] = '{8'hA5, 3'b101, 8'hA5, 1'b0};
        vecs[6] = '{8'hA5, 3'b100, 8'hA5, 1'b1};

        CLEAR = 1'b1; Ser_in = 1'b0; Bit_en = 1'b0; Frame_start = 1'b0; Dack = 1'b0;
        tick(); tick();
        chk("reset_dout",    32'(Dout),    32'h00);
        chk("reset_dvalid",  32'(Dvalid),  32'h0);
        chk("reset_error",   32'(ERROR),   32'h0);
        chk("reset_overrun", 32'(Overrun), 32'h0);
        chk("reset_busy",    32'(Busy),    32'h0);
        CLEAR = 1'b0;
        tick();

        // Continuous strobe: completion on the 11th edge
        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k].data, vecs[k].crc, 0, 11, 1'b0, 1'b1, de, bo);
            chk($sformatf("vec%0d_done_edge", k), 32'(de), 32'd11);
            chk($sformatf("vec%0d_busy", k),      32'(bo), 32'd1);
            chk($sformatf("vec%0d_dout", k),      32'(Dout), 32'(vecs[k].exp_dout));
            chk($sformatf("vec%0d_error", k),     32'(ERROR), 32'(vecs[k].exp_err));
            chk($sformatf("vec%0d_idle", k),      32'(Busy), 32'd0);
            ack_pulse();
            chk($sformatf("vec%0d_acked", k),     32'(Dvalid), 32'd0);
        end

        // Bit_en alternating 1,0: the last strobe lands on edge 21 of 22
        send_frame(8'h80, 3'b011, 1, 11, 1'b0, 1'b1, de, bo);
        chk("gap_done_edge", 32'(de),    32'd21);
        chk("gap_busy",      32'(bo),    32'd1);
        chk("gap_dout",      32'(Dout),  32'h80);
        chk("gap_error",     32'(ERROR), 32'd0);
        ack_pulse();

        // Restart at data bit 3: only the second frame completes
        send_frame(8'h00, 3'b000, 0, 4, 1'b0, 1'b1, de, bo);
        chk("abort_busy",   32'(Busy),   32'd1);
        chk("abort_dvalid", 32'(Dvalid), 32'd0);
        send_frame(8'h80, 3'b011, 0, 11, 1'b0, 1'b1, de, bo);
        chk("restart_done_edge", 32'(de),    32'd11);
        chk("restart_dout",      32'(Dout),  32'h80);
        chk("restart_error",     32'(ERROR), 32'd0);
        ack_pulse();

        // Back-to-back frames without acknowledge
        send_frame(8'h80, 3'b011, 0, 11, 1'b0, 1'b1, de, bo);
        chk("b2b_first_overrun", 32'(Overrun), 32'd0);
        send_frame(8'h00, 3'b000, 0, 11, 1'b0, 1'b1, de, bo);
        chk("b2b_dout",    32'(Dout),    32'h00);
        chk("b2b_dvalid",  32'(Dvalid),  32'd1);
        chk("b2b_overrun", 32'(Overrun), 32'd1);
        ack_pulse();
        chk("b2b_ack_dvalid",  32'(Dvalid),  32'd0);
        chk("b2b_ack_overrun", 32'(Overrun), 32'd0);
        ack_pulse();
        chk("idle_ack_dvalid", 32'(Dvalid), 32'd0);

        // Completion and Dack on the same edge keep Dvalid and Overrun
        send_frame(8'h80, 3'b011, 0, 11, 1'b0, 1'b1, de, bo);
        send_frame(8'h00, 3'b000, 0, 11, 1'b0, 1'b1, de, bo);
        send_frame(8'hA5, 3'b101, 0, 11, 1'b1, 1'b1, de, bo);
        chk("ackdone_dout",    32'(Dout),    32'hA5);
        chk("ackdone_dvalid",  32'(Dvalid),  32'd1);
        chk("ackdone_overrun", 32'(Overrun), 32'd1);
        ack_pulse();

        // Asynchronous clear mid-frame, with a byte held from an earlier frame
        send_frame(8'h80, 3'b011, 0, 11, 1'b0, 1'b1, de, bo);
        send_frame(8'h00, 3'b000, 0, 5, 1'b0, 1'b1, de, bo);
        chk("preclr_busy", 32'(Busy), 32'd1);
        #2;
        CLEAR = 1'b1;
        #1;
        chk("clr_dout",    32'(Dout),    32'h00);
        chk("clr_dvalid",  32'(Dvalid),  32'd0);
        chk("clr_error",   32'(ERROR),   32'd0);
        chk("clr_overrun", 32'(Overrun), 32'd0);
        chk("clr_busy",    32'(Busy),    32'd0);
        #1;
        CLEAR = 1'b0;
        tick();
        send_frame(8'h80, 3'b011, 0, 11, 1'b0, 1'b0, de, bo);
        chk("nostart_busy",   32'(Busy),   32'd0);
        chk("nostart_dvalid", 32'(Dvalid), 32'd0);
        send_frame(8'h80, 3'b011, 0, 11, 1'b0, 1'b1, de, bo);
        chk("postclr_dvalid", 32'(Dvalid), 32'd1);
        chk("postclr_dout",   32'(Dout),   32'h80);
        chk("postclr_error",  32'(ERROR),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
